// File: rtl/dma_engine_if.sv
// rtl/dma_engine_if.sv - shared CPU/memory bus seen by the DMA engine
interface dma_engine_if;
    logic [31:0] Adress;
    logic        read;
    logic        write;
    logic        MTM;
    logic [31:0] Data;
    logic        DAR;
    logic        DR;
    logic        INT;
    logic [31:0] dma_Adress;
    logic        dma_read;
    logic        dma_write;
    logic [31:0] dma_Data;
    logic        bus_oe;
    logic        data_oe;

    // CPU / system side: drives the bus and grant, observes the DMA
    modport master (
        output Adress, read, write, MTM, Data, DAR,
        input  DR, INT, dma_Adress, dma_read, dma_write, dma_Data, bus_oe, data_oe
    );

    // DMA engine side
    modport slave (
        input  Adress, read, write, MTM, Data, DAR,
        output DR, INT, dma_Adress, dma_read, dma_write, dma_Data, bus_oe, data_oe
    );
endinterface

// File: rtl/dma_engine.sv
// rtl/dma_engine.sv - programmable word-copy DMA (memory or fixed I/O source)
module dma_engine #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned ADDR_STEP = 4,
    parameter int          CNT_W     = 16
) (
    input  logic         clk,
    input  logic         reset,
    dma_engine_if.slave  bus
);
    typedef enum logic [3:0] {
        IDLE, LD_SRC, LD_DST, LD_CNT, REQ, RD, RD_WAIT, WR, FIN
    } state_t;

    localparam logic [31:0] STEP = 32'(ADDR_STEP);

    state_t             state;
    logic [31:0]        src;
    logic [31:0]        dst;
    logic [31:0]        data_buf;
    logic [CNT_W-1:0]   cnt;
    logic               mode;

    logic [CNT_W-1:0]   cnt_dec;
    logic [31:0]        src_next;

    // Next counter value and next read address at the end of a word
    always_comb begin
        cnt_dec  = cnt - CNT_W'(1);
        src_next = mode ? src + STEP : src;
    end

    // Sequencer; outputs are registered from the state being entered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            src            <= '0;
            dst            <= '0;
            data_buf       <= '0;
            cnt            <= '0;
            mode           <= 1'b0;
            bus.DR         <= 1'b0;
            bus.INT        <= 1'b0;
            bus.bus_oe     <= 1'b0;
            bus.data_oe    <= 1'b0;
            bus.dma_read   <= 1'b0;
            bus.dma_write  <= 1'b0;
            bus.dma_Adress <= '0;
            bus.dma_Data   <= '0;
        end else begin
            bus.INT <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Adress == BASE_ADDR && !bus.read && !bus.write) begin
                        mode  <= bus.MTM;
                        state <= LD_SRC;
                    end
                end
                LD_SRC: begin
                    src   <= bus.Data;
                    state <= LD_DST;
                end
                LD_DST: begin
                    dst   <= bus.Data;
                    state <= LD_CNT;
                end
                LD_CNT: begin
                    cnt <= bus.Data[CNT_W-1:0];
                    if (bus.Data[CNT_W-1:0] == '0) begin
                        bus.INT <= 1'b1;
                        state   <= FIN;
                    end else begin
                        bus.DR <= 1'b1;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    if (bus.DAR) begin
                        bus.bus_oe     <= 1'b1;
                        bus.dma_read   <= 1'b1;
                        bus.dma_Adress <= src;
                        state          <= RD;
                    end
                end
                RD: begin
                    state <= RD_WAIT;
                end
                RD_WAIT: begin
                    data_buf       <= bus.Data;
                    bus.dma_Data   <= bus.Data;
                    bus.dma_read   <= 1'b0;
                    bus.dma_write  <= 1'b1;
                    bus.data_oe    <= 1'b1;
                    bus.dma_Adress <= dst;
                    state          <= WR;
                end
                WR: begin
                    dst           <= dst + STEP;
                    src           <= src_next;
                    cnt           <= cnt_dec;
                    bus.dma_write <= 1'b0;
                    bus.data_oe   <= 1'b0;
                    if (cnt_dec == '0) begin
                        bus.INT        <= 1'b1;
                        bus.DR         <= 1'b0;
                        bus.bus_oe     <= 1'b0;
                        bus.dma_Adress <= '0;
                        state          <= FIN;
                    end else begin
                        bus.dma_read   <= 1'b1;
                        bus.dma_Adress <= src_next;
                        state          <= RD;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dma_engine.sv
// tb/tb_dma_engine.sv - self-checking bench for dma_engine
module tb_dma_engine;
    localparam logic [31:0] BASE  = 32'h8000_0040;
    localparam logic [31:0] NOISE = 32'h1234_5670;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] prog_data;
    logic [31:0] salt;
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    dma_engine_if bif ();

    dma_engine #(.BASE_ADDR(BASE), .ADDR_STEP(4), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    function automatic logic [31:0] mem_val(input logic [31:0] a, input logic [31:0] s);
        return (a * 32'h9E37_79B1) ^ s;
    endfunction

    // Memory answers DMA reads; otherwise the CPU drives programming words
    assign bif.Data = (bif.bus_oe && bif.dma_read) ? mem_val(bif.dma_Adress, salt) : prog_data;

    function automatic logic [69:0] outs();
        return {bif.DR, bif.INT, bif.bus_oe, bif.data_oe, bif.dma_read, bif.dma_write,
                bif.dma_Adress, bif.dma_Data};
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic program_job(input logic m, input logic [31:0] s, input logic [31:0] d,
                               input logic [15:0] n);
        bif.Adress = BASE; bif.read = 1'b0; bif.write = 1'b0; bif.MTM = m;
        @(posedge clk); #1;
        bif.Adress = NOISE; bif.MTM = ~m; prog_data = s;
        @(posedge clk); #1;
        prog_data = d;
        @(posedge clk); #1;
        prog_data = {16'hBEEF, n};
        @(posedge clk); #1;
        prog_data = 32'h0;
    endtask

    task automatic run_job(input string tag, input logic m, input logic [31:0] s,
                           input logic [31:0] d, input logic [15:0] n, input int gdly,
                           output int int_cyc, output logic [31:0] last_wr);
        logic [31:0] rd_q[$];
        logic [31:0] wr_a[$];
        logic [31:0] wr_d[$];
        logic [31:0] ex_rd[$];
        logic [31:0] ex_a[$];
        logic [31:0] ex_d[$];
        int first_rd = -1;
        int ints = 0;
        int dr_cnt = 0;
        int dr_bad = 0;
        int cyc = 0;
        int limit;
        int exp_int;
        bit done = 0;
        bit ok;
        int_cyc = -1;
        last_wr = 32'h0;
        salt = $urandom;
        program_job(m, s, d, n);
        bif.Adress = BASE;
        limit = 3 * int'(n) + gdly + 20;
        while (!done && cyc < limit) begin
            @(negedge clk);
            if (bif.DR) begin
                if (dr_cnt == gdly) bif.DAR = 1'b1;
                dr_cnt++;
            end
            if (bif.bus_oe && !bif.DR) dr_bad++;
            if (bif.bus_oe && bif.dma_read) begin
                if (first_rd < 0) first_rd = cyc;
                rd_q.push_back(bif.dma_Adress);
            end
            if (bif.bus_oe && bif.dma_write && bif.data_oe) begin
                wr_a.push_back(bif.dma_Adress);
                wr_d.push_back(bif.dma_Data);
            end
            if (bif.INT) begin
                ints++;
                if (int_cyc < 0) begin
                    int_cyc = cyc;
                    chk({tag, "_dr_low_at_int"}, {bif.DR, bif.bus_oe}, 2'b00);
                end
                bif.Adress = NOISE;
                bif.DAR = 1'b0;
            end
            if (int_cyc >= 0 && cyc > int_cyc + 1) done = 1;
            @(posedge clk); #1;
            cyc++;
        end
        bif.Adress = NOISE;
        bif.DAR = 1'b0;

        for (int i = 0; i < int'(n); i++) begin
            logic [31:0] sa;
            sa = m ? s + 32'(4 * i) : s;
            ex_rd.push_back(sa);
            ex_rd.push_back(sa);
            ex_a.push_back(d + 32'(4 * i));
            ex_d.push_back(mem_val(sa, salt));
        end
        exp_int = (n == 0) ? 0 : gdly + 1 + 3 * int'(n);
        chk({tag, "_int_cycle"}, int_cyc, exp_int);
        chk({tag, "_int_pulses"}, ints, 1);
        chk({tag, "_dr_held"}, dr_bad, 0);

        ok = (rd_q.size() == ex_rd.size());
        if (ok) foreach (ex_rd[i]) if (rd_q[i] !== ex_rd[i]) ok = 0;
        chk({tag, "_reads"}, {rd_q.size(), 31'h0, ok}, {ex_rd.size(), 31'h0, 1'b1});
        ok = (wr_a.size() == ex_a.size());
        if (ok) foreach (ex_a[i]) if (wr_a[i] !== ex_a[i] || wr_d[i] !== ex_d[i]) ok = 0;
        chk({tag, "_writes"}, {wr_a.size(), 31'h0, ok}, {ex_a.size(), 31'h0, 1'b1});
        if (n == 0) chk({tag, "_no_dr"}, dr_cnt, 0);
        else        chk({tag, "_first_rd"}, first_rd, gdly + 1);
        if (wr_a.size() > 0) last_wr = wr_a[$];
    endtask

    typedef struct {
        string       name;
        logic        mode;
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] cnt;
        int          gdly;
        int          exp_int;
        logic [31:0] exp_last_wr;
    } vec_t;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[5];
        int ic;
        int act;
        logic [31:0] lw;

        vecs[0] = '{"mtm_copy", 1'b1, 32'h100,       32'h200,       16'd3, 2, 12, 32'h208};
        vecs[1] = '{"io_to_mem", 1'b0, 32'h40,       32'h300,       16'd2, 0, 7,  32'h304};
        vecs[2] = '{"zero_cnt", 1'b1, 32'h700,       32'h800,       16'd0, 0, 0,  32'h0};
        vecs[3] = '{"dst_wrap", 1'b1, 32'h500,       32'hFFFF_FFFC, 16'd2, 1, 8,  32'h0};
        vecs[4] = '{"src_wrap", 1'b1, 32'hFFFF_FFF8, 32'h10,        16'd3, 0, 10, 32'h18};

        reset = 1'b1;
        bif.Adress = NOISE; bif.read = 1'b0; bif.write = 1'b0; bif.MTM = 1'b0; bif.DAR = 1'b0;
        prog_data = 32'h0; salt = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", outs(), 70'h0);
        reset = 1'b0;

        // Address match with a strobe active is not a select
        bif.Adress = BASE; bif.read = 1'b1;
        @(posedge clk); #1;
        bif.read = 1'b0; bif.write = 1'b1;
        @(posedge clk); #1;
        bif.write = 1'b0; bif.Adress = NOISE;
        act = 0;
        repeat (6) begin
            @(negedge clk);
            if (bif.DR | bif.INT | bif.bus_oe) act++;
        end
        chk("no_select_with_strobe", act, 0);

        // Asynchronous reset while idle
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk("idle_async_reset", outs(), 70'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        foreach (vecs[i]) begin
            run_job(vecs[i].name, vecs[i].mode, vecs[i].src, vecs[i].dst, vecs[i].cnt,
                    vecs[i].gdly, ic, lw);
            chk({vecs[i].name, "_tbl_int"}, ic, vecs[i].exp_int);
            chk({vecs[i].name, "_tbl_last_wr"}, lw, vecs[i].exp_last_wr);
            repeat (2) @(posedge clk);
            #1;
        end

        for (int j = 0; j < 6; j++) begin
            logic        m;
            logic [31:0] s;
            logic [31:0] d;
            m = 1'($urandom_range(0, 1));
            s = $urandom & 32'hFFFF_FFFC;
            d = $urandom & 32'hFFFF_FFFC;
            run_job($sformatf("rand%0d", j), m, s, d, 16'($urandom_range(1, 5)),
                    int'($urandom_range(0, 4)), ic, lw);
            repeat (int'($urandom_range(1, 3))) @(posedge clk);
            #1;
        end

        // Abort during the second RD_WAIT of a 4-word job; grant already held
        salt = 32'h5A5A_0001;
        bif.DAR = 1'b1;
        program_job(1'b1, 32'h1000, 32'h2000, 16'd4);
        @(negedge clk);
        chk("grant_not_same_edge", {bif.DR, bif.bus_oe}, 2'b10);
        @(negedge clk);
        chk("rd_after_grant", {bif.bus_oe, bif.dma_read, bif.dma_Adress}, {2'b11, 32'h1000});
        repeat (4) @(negedge clk);
        chk("second_rd_wait", {bif.bus_oe, bif.dma_read, bif.dma_Adress}, {2'b11, 32'h1004});
        #1;
        reset = 1'b1;
        #1;
        chk("abort_async_reset", outs(), 70'h0);
        bif.DAR = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        act = 0;
        repeat (8) begin
            @(negedge clk);
            if (bif.INT | bif.DR) act++;
        end
        chk("abort_no_int", act, 0);
        @(posedge clk); #1;
        run_job("after_abort", 1'b1, 32'h3000, 32'h4000, 16'd1, 1, ic, lw);
        chk("after_abort_last_wr", lw, 32'h4000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/dma_engine.md
# dma_engine

Bus-responder and bus-master DMA block paired with the `cpu` initiator. It accepts the CPU's three-word programming burst (source, destination, count), raises `DR`, waits for the CPU to grant the bus with `DAR`, then moves `count` words either memory-to-memory (`MTM=1`) or from a fixed I/O port to memory (`MTM=0`). It signals completion to the CPU on `INT`. It sits on the shared `Adress`/`Data` bus next to memory and the I/O devices.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: DMA select address on `Adress`.
- `ADDR_STEP`, default 4: byte increment per transferred word.
- `CNT_W`, default 16: width of the word counter, taken from `Data[CNT_W-1:0]`.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; forces all state and outputs to reset values.
- `Adress`  in  32  CPU address bus, used for selection while idle.
- `read`  in  1  CPU read strobe.
- `write`  in  1  CPU write strobe.
- `MTM`  in  1  mode from CPU: 1 = memory-to-memory, 0 = I/O-to-memory; sampled in the select cycle.
- `Data`  in  32  shared data bus, input side.
- `DAR`  in  1  bus grant from CPU.
- `DR`  out  1  bus request to CPU.
- `INT`  out  1  completion pulse to CPU.
- `dma_Adress`  out  32  address driven when mastering.
- `dma_read`  out  1  read strobe when mastering.
- `dma_write`  out  1  write strobe when mastering.
- `dma_Data`  out  32  write data.
- `bus_oe`  out  1  1 = top level muxes the `dma_*` signals onto the bus.
- `data_oe`  out  1  1 = `dma_Data` drives `Data`.

## Operation
- States: IDLE, LD_SRC, LD_DST, LD_CNT, REQ, RD, RD_WAIT, WR, FIN.
- IDLE: a select cycle is an edge where `Adress==BASE_ADDR`, `read==0` and `write==0`. On a select cycle, latch `MTM` into `mode` and go to LD_SRC.
- LD_SRC, LD_DST, LD_CNT: on each edge, capture `Data` into `src`, `dst`, then `cnt` (low `CNT_W` bits), one state per edge.
- After LD_CNT:
  - If `cnt==0`, go to FIN with no bus request.
  - Otherwise go to REQ.
- REQ: `DR=1`. Hold until an edge with `DAR==1`, then go to RD.
- RD: `bus_oe=1`, `dma_Adress=src`, `dma_read=1`. Then go to RD_WAIT.
- RD_WAIT: `bus_oe=1`, `dma_Adress=src`, `dma_read=1`. Capture `Data` into `buf` at the closing edge. Then go to WR.
- WR: `bus_oe=1`, `data_oe=1`, `dma_Adress=dst`, `dma_write=1`, `dma_Data=buf`. At the closing edge:
  - `dst += ADDR_STEP`.
  - `src += ADDR_STEP` only if `mode==1`; the I/O source address stays fixed.
  - `cnt -= 1`.
  - Go to FIN if the new `cnt==0`, else go to RD.
- FIN: `INT=1` for exactly one cycle, `DR=0`, `bus_oe=0`. Then return to IDLE.
- `DR` stays 1 from REQ through the last WR inclusive. `DAR` is not re-checked after the grant; the CPU holds it until `INT`.
- Address arithmetic is modulo 2^32 and wraps silently (32'hFFFF_FFFC + 4 = 0).
- Select cycles seen outside IDLE are ignored. Reprogramming is not possible mid-transfer.

## Timing
- Reset values: `DR=0`, `INT=0`, `bus_oe=0`, `data_oe=0`, `dma_read=0`, `dma_write=0`, `dma_Adress=0`, `dma_Data=0`; internal `src`, `dst`, `cnt`, `buf` and `mode` = 0; state IDLE.
- `reset` asserted mid-transfer aborts immediately: all outputs return to reset values asynchronously, and no `INT` is issued.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- `DR` rises in the cycle after the LD_CNT edge, i.e. 4 cycles after the select edge. This is visible to the CPU on its grant-check cycle.
- Grant latency is unbounded; REQ waits indefinitely.
- Each word takes 3 cycles (RD, RD_WAIT, WR). A transfer of N words occupies the bus for 3N cycles from the first RD; `INT` follows in the next cycle.
- Zero count: `INT` asserts 1 cycle after LD_CNT, and `DR` never rises.
- `DAR` arriving in the same edge as the transition into REQ is not sampled; sampling starts in REQ.

## Test plan
- Reset: assert `reset` mid-cycle while idle -> all outputs 0 immediately; state IDLE after release.
- MTM copy: select with `MTM=1`, Data 32'h100, 32'h200, 3, grant 2 cycles after `DR` -> reads at 0x100/0x104/0x108, writes at 0x200/0x204/0x208 with the returned data; `INT` one cycle after last WR; `DR` low at FIN.
- I/O-to-memory: `MTM=0`, src 32'h40, dst 32'h300, count 2 -> both reads at 0x40; writes at 0x300 and 0x304.
- Zero count: program count 0 -> `DR` never asserted; `INT` pulse 1 cycle after LD_CNT.
- Wrap: dst 32'hFFFF_FFFC, count 2 -> writes at 0xFFFF_FFFC then 0x0000_0000.
- Abort: assert `reset` during the second RD_WAIT of a 4-word job -> outputs to reset values at once, no `INT`; a fresh 1-word job afterwards completes normally.
